snow_pos_gen: RTL and testbench
===============================

SNOW_POS_GEN -- requirements
Module: snow_pos_gen

Interface
REQ-001 Parameter TICK, default 6000000: frame-tick count; ipcnt counts 0..TICK inclusive.
REQ-002 Parameter STEP, default 4: pixels moved per tick, horizontal and vertical.
REQ-003 Parameter X0, default 288: reset and home x of the sprite's top-left corner.
REQ-004 Parameter Y0, default 400: reset and ground y of the sprite's top-left corner.
REQ-005 Parameter JUMP_H, default 96: jump apex height above Y0, in pixels.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset; clk and rst are named as elsewhere in the codebase.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 h_addr  input  10  current VGA pixel column, 0..639.
REQ-010 v_addr  input  9  current VGA pixel row, 0..479.
REQ-011 left  input  1  move-left request, level sampled at tick.
REQ-012 right  input  1  move-right request, level sampled at tick.
REQ-013 jump  input  1  jump request, level sampled at tick.
REQ-014 ipcnt  output  32  free-running tick counter; feeds snow_show.
REQ-015 snow  output  12  64x64 sprite ROM address {dy[5:0],dx[5:0]}; feeds snow_show.
REQ-016 snowf_get  output  1  1 = pixel outside sprite, so downstream forces background colour.

Function
REQ-017 ipcnt SHALL increment by 1 every cycle and, when equal to TICK, load 0 on the next cycle, giving a period of TICK+1 cycles.
REQ-018 A tick SHALL be the single cycle in which ipcnt == TICK; all position and FSM updates SHALL occur only in that cycle.
REQ-019 Sprite position registers: px is 10 bits, py is 9 bits, both the top-left corner of the sprite.
REQ-020 On a tick with left=1 and right=0, px SHALL become max(px-STEP, 0).
REQ-021 On a tick with right=1 and left=0, px SHALL become min(px+STEP, 576).
REQ-022 On a tick with left=right=1, or with both 0, px SHALL be unchanged.
REQ-023 The vertical FSM SHALL have the states GROUND, RISE and FALL.
REQ-024 GROUND: py = Y0; on a tick with jump=1, the FSM SHALL go to RISE with no py change on that tick.
REQ-025 RISE: each tick, py SHALL become py-STEP; when the new py <= Y0-JUMP_H, py SHALL be clamped to Y0-JUMP_H and the FSM SHALL go to FALL.
REQ-026 FALL: each tick, py SHALL become py+STEP; when the new py >= Y0, py SHALL be clamped to Y0 and the FSM SHALL go to GROUND.
REQ-027 jump SHALL be ignored in RISE and FALL; re-triggering requires a tick in GROUND with jump=1.
REQ-028 Horizontal and vertical updates on the same tick SHALL both apply.
REQ-029 inside SHALL be true when px <= h_addr < px+64 and py <= v_addr < py+64, using the px and py values current in that cycle; comparisons SHALL be unsigned with 11-bit and 10-bit intermediates so px+64 cannot overflow.
REQ-030 snow and snowf_get SHALL be registered with 1-cycle latency from h_addr/v_addr.
REQ-031 If inside: snow = {(v_addr-py)[5:0], (h_addr-px)[5:0]} and snowf_get = 0.
REQ-032 If not inside: snow = 0 and snowf_get = 1.
REQ-033 Position changes SHALL affect address output from the cycle after the tick.

Reset
REQ-034 When rst=1 at a clk edge: ipcnt=0, px=X0, py=Y0, FSM=GROUND, snow=0, snowf_get=1.
REQ-035 Reset SHALL override everything, including mid-jump and a coincident tick.
REQ-036 After reset is released, the first tick SHALL occur TICK cycles later.

Verification
REQ-037 Bench SHALL use TICK=9. Release reset -> ipcnt steps 0,1,...,9,0; tick asserted once every 10 cycles.
REQ-038 right=1 held for 3 ticks -> px 288→292→296→300; with px=574, one tick -> px=576; a further tick -> px stays 576.
REQ-039 left=right=1 for 2 ticks -> px unchanged at 288; left only with px=2, one tick -> px=0.
REQ-040 jump=1 for one tick from GROUND -> RISE. py falls 400→304 over 24 ticks, then FALL, and returns to 400 (GROUND) 24 ticks later. A jump held throughout is ignored until GROUND.
REQ-041 px=288, py=400, h_addr=300, v_addr=405 -> next cycle snow={6'd5,6'd12}=0x14C, snowf_get=0. h_addr=352 -> snow=0, snowf_get=1. h_addr=287 -> snowf_get=1.
REQ-042 rst=1 asserted in RISE at py=352 during a tick cycle -> next cycle py=400, GROUND, ipcnt=0, snowf_get=1.

Source files
------------

// File: rtl/snow_pos_gen.sv
// Snowman sprite position generator: frame-tick counter, left/right walking
// with screen clamps, a ground/rise/fall jump FSM, and a registered 64x64 ROM address.
module snow_pos_gen #(
  parameter int unsigned TICK   = 6000000,
  parameter int unsigned STEP   = 4,
  parameter int unsigned X0     = 288,
  parameter int unsigned Y0     = 400,
  parameter int unsigned JUMP_H = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_addr,
  input  logic [8:0]  v_addr,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  output logic [31:0] ipcnt,
  output logic [11:0] snow,
  output logic        snowf_get
);

  localparam logic [9:0] X_MAX  = 10'd576;   // 640 - sprite width
  localparam logic [9:0] X_HOME = 10'(X0);
  localparam logic [9:0] STEP_H = 10'(STEP);
  localparam logic [8:0] STEP_V = 9'(STEP);
  localparam logic [8:0] Y_GND  = 9'(Y0);
  localparam logic [8:0] Y_TOP  = 9'(Y0 - JUMP_H);

  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

  vstate_t    vstate;
  logic [9:0] px;
  logic [9:0] px_nxt;
  logic [8:0] py;
  logic       tick;
  logic       in_h;
  logic       in_v;

  assign tick = (ipcnt == TICK);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    px_nxt = px;
    if (left && !right) begin
      px_nxt = (px >= STEP_H) ? px - STEP_H : '0;
    end else if (right && !left) begin
      px_nxt = (px + STEP_H >= X_MAX) ? X_MAX : px + STEP_H;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ipcnt  <= '0;
      px     <= X_HOME;
      py     <= Y_GND;
      vstate <= GROUND;
    end else begin
      ipcnt <= tick ? '0 : ipcnt + 32'd1;
      if (tick) begin
        px <= px_nxt;
        case (vstate)
          GROUND: if (jump) vstate <= RISE;
          RISE: begin
            // Compare before subtracting so the apex clamp never wraps below zero.
            if ({1'b0, py} <= {1'b0, Y_TOP} + {1'b0, STEP_V}) begin
              py     <= Y_TOP;
              vstate <= FALL;
            end else begin
              py <= py - STEP_V;
            end
          end
          FALL: begin
            if ({1'b0, py} + {1'b0, STEP_V} >= {1'b0, Y_GND}) begin
              py     <= Y_GND;
              vstate <= GROUND;
            end else begin
              py <= py + STEP_V;
            end
          end
          default: vstate <= GROUND;
        endcase
      end
    end
  end

  // Widened compares keep px+64 / py+64 from wrapping near the screen edge.
  assign in_h = ({1'b0, h_addr} >= {1'b0, px}) && ({1'b0, h_addr} < {1'b0, px} + 11'd64);
  assign in_v = ({1'b0, v_addr} >= {1'b0, py}) && ({1'b0, v_addr} < {1'b0, py} + 10'd64);

  always_ff @(posedge clk) begin
    if (rst) begin
      snow      <= '0;
      snowf_get <= 1'b1;
    end else if (in_h && in_v) begin
      snow      <= {6'(v_addr - py), 6'(h_addr - px)};
      snowf_get <= 1'b0;
    end else begin
      snow      <= '0;
      snowf_get <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snow_pos_gen.sv
// Bench for snow_pos_gen: two instances (home x 288 and 290, so both screen
// clamps are reachable in whole steps) checked against a plain-integer model.
module tb_snow_pos_gen;

  localparam int TICK   = 9;
  localparam int STEP   = 4;
  localparam int Y0     = 400;
  localparam int JUMP_H = 96;
  localparam int X0_A   = 288;
  localparam int X0_B   = 290;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_addr = '0;
  logic [8:0]  v_addr = '0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] ipcnt_a, ipcnt_b;
  logic [11:0] snow_a, snow_b;
  logic        f_a, f_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  snow_pos_gen #(.TICK(TICK), .STEP(STEP), .X0(X0_A), .Y0(Y0), .JUMP_H(JUMP_H)) dut_a (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr),
    .left(left), .right(right), .jump(jump),
    .ipcnt(ipcnt_a), .snow(snow_a), .snowf_get(f_a)
  );

  snow_pos_gen #(.TICK(TICK), .STEP(STEP), .X0(X0_B), .Y0(Y0), .JUMP_H(JUMP_H)) dut_b (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr),
    .left(left), .right(right), .jump(jump),
    .ipcnt(ipcnt_b), .snow(snow_b), .snowf_get(f_b)
  );

  // Reference model: positions as plain integers, state 0=ground 1=rise 2=fall.
  int          m_cnt;
  int          m_px[2];
  int          m_py[2];
  int          m_st[2];
  logic [11:0] m_snow[2];
  logic        m_f[2];
  int          m_h, m_v;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        m_px[k]   = (k == 0) ? X0_A : X0_B;
        m_py[k]   = Y0;
        m_st[k]   = 0;
        m_snow[k] = '0;
        m_f[k]    = 1'b1;
      end
    end else begin
      m_h = int'(h_addr);
      m_v = int'(v_addr);
      for (int k = 0; k < 2; k++) begin
        if (m_h >= m_px[k] && m_h < m_px[k] + 64 && m_v >= m_py[k] && m_v < m_py[k] + 64) begin
          m_snow[k] = {6'(m_v - m_py[k]), 6'(m_h - m_px[k])};
          m_f[k]    = 1'b0;
        end else begin
          m_snow[k] = '0;
          m_f[k]    = 1'b1;
        end
        if (m_cnt == TICK) begin
          if (left && !right)      m_px[k] = (m_px[k] - STEP < 0) ? 0 : m_px[k] - STEP;
          else if (right && !left) m_px[k] = (m_px[k] + STEP > 576) ? 576 : m_px[k] + STEP;
          if (m_st[k] == 0) begin
            if (jump) m_st[k] = 1;
          end else if (m_st[k] == 1) begin
            m_py[k] = m_py[k] - STEP;
            if (m_py[k] <= Y0 - JUMP_H) begin m_py[k] = Y0 - JUMP_H; m_st[k] = 2; end
          end else begin
            m_py[k] = m_py[k] + STEP;
            if (m_py[k] >= Y0) begin m_py[k] = Y0; m_st[k] = 0; end
          end
        end
      end
      m_cnt = (m_cnt == TICK) ? 0 : m_cnt + 1;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Returns one negedge after the next tick edge has been applied.
  task automatic wait_tick();
    int n = 0;
    while (m_cnt != TICK && n < 2 * (TICK + 1)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; left = 1'b0; right = 1'b0; jump = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    tests_run++;
    if ({ipcnt_a, snow_a, f_a, ipcnt_b, snow_b, f_b} !== {32'd0, 12'd0, 1'b1, 32'd0, 12'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: ipcnt=%0d/%0d snow=%h/%h f=%b/%b, expected 0 000 1", ipcnt_a, ipcnt_b, snow_a, snow_b, f_a, f_b);
    end
  endtask

  task automatic test_counter();
    rst = 1'b0;
    for (int i = 1; i <= 2 * (TICK + 1); i++) begin
      cyc();
      tests_run++;
      if (ipcnt_a !== 32'(i % (TICK + 1)) || ipcnt_b !== 32'(i % (TICK + 1))) begin
        tests_failed++;
        $display("FAIL counter_step%0d: ipcnt=%0d/%0d expected %0d", i, ipcnt_a, ipcnt_b, i % (TICK + 1));
      end
    end
  endtask

  task automatic test_address();
    do_reset();
    h_addr = 10'd300; v_addr = 9'd405; cyc();
    tests_run++;
    if ({snow_a, f_a, snow_b, f_b} !== {12'h14C, 1'b0, m_snow[1], m_f[1]}) begin
      tests_failed++;
      $display("FAIL addr_inside: snow=%h/%h f=%b/%b expected 14c/0 and %h/%b", snow_a, snow_b, f_a, f_b, m_snow[1], m_f[1]);
    end
    h_addr = 10'd352; cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b1}) begin
      tests_failed++;
      $display("FAIL addr_right_edge: snow=%h f=%b expected 000/1", snow_a, f_a);
    end
    h_addr = 10'd287; cyc();
    tests_run++;
    if (f_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL addr_left_edge: f=%b expected 1", f_a);
    end
    h_addr = 10'd351; v_addr = 9'd463; cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'hFFF, 1'b0}) begin
      tests_failed++;
      $display("FAIL addr_corner: snow=%h f=%b expected fff/0", snow_a, f_a);
    end
    v_addr = 9'd464; cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b1}) begin
      tests_failed++;
      $display("FAIL addr_bottom_edge: snow=%h f=%b expected 000/1", snow_a, f_a);
    end
  endtask

  task automatic test_move_right();
    do_reset();
    right = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      h_addr = 10'(X0_A + STEP * t); v_addr = 9'(Y0); cyc();
      tests_run++;
      if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
        tests_failed++;
        $display("FAIL right_tick%0d: snow=%h f=%b expected 000/0 at x=%0d", t, snow_a, f_a, X0_A + STEP * t);
      end
      h_addr = 10'(X0_A + STEP * t - 1); cyc();
      tests_run++;
      if (f_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL right_tick%0d_left_of: f=%b expected 1", t, f_a);
      end
    end
    repeat (68) wait_tick();
    h_addr = 10'd574; v_addr = 9'(Y0); cyc();
    tests_run++;
    if ({snow_b, f_b} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL right_at_574: snow=%h f=%b expected 000/0", snow_b, f_b);
    end
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      h_addr = 10'd576; cyc();
      tests_run++;
      if ({snow_b, f_b, snow_a, f_a} !== {12'h000, 1'b0, 12'h000, 1'b0}) begin
        tests_failed++;
        $display("FAIL right_clamp%0d: snow=%h/%h f=%b/%b expected 000/0", t, snow_a, snow_b, f_a, f_b);
      end
      h_addr = 10'd575; cyc();
      tests_run++;
      if (f_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL right_clamp%0d_left_of: f=%b expected 1", t, f_b);
      end
    end
    right = 1'b0;
  endtask

  task automatic test_move_left();
    do_reset();
    left = 1'b1; right = 1'b1;
    repeat (2) wait_tick();
    h_addr = 10'(X0_A); v_addr = 9'(Y0); cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL both_dirs_hold: snow=%h f=%b expected 000/0", snow_a, f_a);
    end
    h_addr = 10'(X0_A - 1); cyc();
    tests_run++;
    if (f_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_dirs_left_of: f=%b expected 1", f_a);
    end
    right = 1'b0;
    repeat (72) wait_tick();
    h_addr = 10'd2; cyc();
    tests_run++;
    if ({snow_b, f_b} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL left_at_2: snow=%h f=%b expected 000/0", snow_b, f_b);
    end
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      h_addr = 10'd1; cyc();
      tests_run++;
      if ({snow_b, f_b, snow_a, f_a} !== {12'h001, 1'b0, 12'h001, 1'b0}) begin
        tests_failed++;
        $display("FAIL left_clamp%0d: snow=%h/%h f=%b/%b expected 001/0", t, snow_a, snow_b, f_a, f_b);
      end
    end
    left = 1'b0;
  endtask

  task automatic test_jump();
    int exp_py;
    do_reset();
    jump = 1'b1;
    wait_tick();
    h_addr = 10'(X0_A); v_addr = 9'(Y0); cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL jump_trigger_no_move: snow=%h f=%b expected 000/0", snow_a, f_a);
    end
    for (int t = 1; t <= 48; t++) begin
      wait_tick();
      exp_py = (t <= 24) ? Y0 - STEP * t : (Y0 - JUMP_H) + STEP * (t - 24);
      v_addr = 9'(exp_py); cyc();
      tests_run++;
      if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
        tests_failed++;
        $display("FAIL jump_tick%0d: snow=%h f=%b expected 000/0 at y=%0d", t, snow_a, f_a, exp_py);
      end
      if (t == 24 || t == 48) begin
        v_addr = 9'(exp_py - 1); cyc();
        tests_run++;
        if (f_a !== 1'b1) begin
          tests_failed++;
          $display("FAIL jump_tick%0d_above: f=%b expected 1", t, f_a);
        end
      end
    end
    repeat (2) wait_tick();
    v_addr = 9'(Y0 - STEP); cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL jump_retrigger: snow=%h f=%b expected 000/0 at y=%0d", snow_a, f_a, Y0 - STEP);
    end
    jump = 1'b0;
  endtask

  task automatic test_reset_midjump();
    int n = 0;
    do_reset();
    jump = 1'b1;
    wait_tick();
    jump = 1'b0;
    repeat (12) wait_tick();
    h_addr = 10'(X0_A); v_addr = 9'd352; cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL midjump_py352: snow=%h f=%b expected 000/0", snow_a, f_a);
    end
    while (m_cnt != TICK && n < 2 * (TICK + 1)) begin cyc(); n++; end
    rst = 1'b1; cyc();
    tests_run++;
    if ({ipcnt_a, snow_a, f_a} !== {32'd0, 12'h000, 1'b1}) begin
      tests_failed++;
      $display("FAIL midjump_reset: ipcnt=%0d snow=%h f=%b expected 0 000 1", ipcnt_a, snow_a, f_a);
    end
    rst = 1'b0; v_addr = 9'(Y0); cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL midjump_home: snow=%h f=%b expected 000/0", snow_a, f_a);
    end
    repeat (2) wait_tick();
    cyc();
    tests_run++;
    if ({snow_a, f_a} !== {12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL midjump_stays_ground: snow=%h f=%b expected 000/0", snow_a, f_a);
    end
  endtask

  task automatic test_random();
    int h, v;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      left  = 1'($urandom_range(0, 1));
      right = 1'($urandom_range(0, 1));
      jump  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      h = m_px[i % 2] + int'($urandom_range(0, 84)) - 10;
      v = m_py[i % 2] + int'($urandom_range(0, 84)) - 10;
      h_addr = 10'((h < 0) ? 0 : (h > 639) ? 639 : h);
      v_addr = 9'((v < 0) ? 0 : (v > 479) ? 479 : v);
      cyc();
      tests_run++;
      if ({ipcnt_a, snow_a, f_a, ipcnt_b, snow_b, f_b} !==
          {32'(m_cnt), m_snow[0], m_f[0], 32'(m_cnt), m_snow[1], m_f[1]}) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: ipcnt=%0d/%0d snow=%h/%h f=%b/%b expected %0d %h/%h %b/%b",
                 i, ipcnt_a, ipcnt_b, snow_a, snow_b, f_a, f_b, m_cnt, m_snow[0], m_snow[1], m_f[0], m_f[1]);
      end
    end
    rst = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_address();
    test_move_right();
    test_move_left();
    test_jump();
    test_reset_midjump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
